// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU command sequencer.
// seq_entry_t shows the program entry layout at the default 8-bit operand width;
// the RTL slices entries generically so other WIDTH values keep the same order.
package cpu_seq_pkg;

    localparam logic [6:0] CMD_NOP    = 7'h00;
    localparam int         CMD_W      = 7;
    localparam int         SEQ_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [CMD_W-1:0]      cmd;
        logic [SEQ_DATA_W-1:0] d1;
        logic [SEQ_DATA_W-1:0] d2;
        logic [SEQ_DATA_W-1:0] d3;
        logic [SEQ_DATA_W-1:0] d4;
    } seq_entry_t;

    // States in which the shared timeout counter runs.
    function automatic logic is_wait_state(seq_state_t s);
        return (s == WAIT_RDY) || (s == WAIT_BUSY) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Small register-array memory: synchronous write, asynchronous read.
// A read of the address being written returns the old contents.
// CLEAR_ON_RST selects whether the synchronous reset also zeroes the array.
module seq_prog_mem #(
    parameter int DEPTH        = 16,
    parameter int W            = 8,
    parameter bit CLEAR_ON_RST = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Write port, with optional clear on reset.
    always_ff @(posedge i_clk) begin
        if (CLEAR_ON_RST && i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// Host-side command sequencer: steps through a loadable program buffer, issues
// one command per entry to the CPU, paces on cpu_rdy and captures the results.
// Optional feature: define CPU_SEQ_RESULT_LOG_EN to add a per-entry result log
// readable through res_addr/res_data.
module cpu_cmd_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH)-1:0]   last_idx,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [7+4*WIDTH-1:0]       prog_wdata,
    output logic [6:0]                 cmd_out,
    output logic [WIDTH-1:0]           d_out1,
    output logic [WIDTH-1:0]           d_out2,
    output logic [WIDTH-1:0]           d_out3,
    output logic [WIDTH-1:0]           d_out4,
    input  logic                       cpu_rdy,
    input  logic [2*WIDTH-1:0]         res_in,
    input  logic                       zero_in,
    input  logic                       error_in,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic                       err_seen,
    output logic [2*WIDTH-1:0]         last_result,
    output logic                       last_zero
`ifdef CPU_SEQ_RESULT_LOG_EN
    ,
    input  logic [$clog2(DEPTH)-1:0]   res_addr,
    output logic [2*WIDTH+1:0]         res_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 7 + 4*WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic                w_abort;
    logic [AW-1:0]       r_pc;
    logic [AW-1:0]       r_last;
    logic [TW-1:0]       r_tmo;
    logic                w_tmo_hit;
    logic                r_timeout_err;
    logic                r_err_seen;
    logic [2*WIDTH-1:0]  r_last_result;
    logic                r_last_zero;
    logic [EW-1:0]       w_entry;
    logic                w_prog_we;
    logic                w_hold_data;

    // Program writes are locked out for the whole run so the entry being
    // executed cannot change under the CPU.
    assign w_prog_we = prog_we && !busy;

    seq_prog_mem #(
        .DEPTH        (DEPTH),
        .W            (EW),
        .CLEAR_ON_RST (1'b0)
    ) u_prog_mem (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_we    (w_prog_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_entry)
    );

`ifdef CPU_SEQ_RESULT_LOG_EN
    logic w_log_we;

    // Aborted entries never reach CAPTURE, so they leave the log untouched.
    assign w_log_we = (r_state == CAPTURE);

    seq_prog_mem #(
        .DEPTH        (DEPTH),
        .W            (2*WIDTH+2),
        .CLEAR_ON_RST (1'b1)
    ) u_result_log (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_we    (w_log_we),
        .i_waddr (r_pc),
        .i_wdata ({zero_in, error_in, res_in}),
        .i_raddr (res_addr),
        .o_rdata (res_data)
    );
`endif

    // Last cycle allowed in a wait state before the run is aborted.
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a satisfied handshake wins over a timeout in the same cycle.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (cpu_rdy) begin
                    w_next = ISSUE;
                end else if (w_tmo_hit) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            ISSUE: begin
                w_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!cpu_rdy) begin
                    w_next = WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (cpu_rdy) begin
                    w_next = CAPTURE;
                end else if (w_tmo_hit) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            CAPTURE: begin
                w_next = (r_pc == r_last) ? DONE : WAIT_RDY;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Command strobe for one cycle in ISSUE; operands held until the result is captured.
    assign w_hold_data = (r_state == ISSUE) || (r_state == WAIT_BUSY) ||
                         (r_state == WAIT_DONE) || (r_state == CAPTURE);

    always_comb begin
        cmd_out = CMD_NOP;
        d_out1  = '0;
        d_out2  = '0;
        d_out3  = '0;
        d_out4  = '0;
        if (r_state == ISSUE) begin
            cmd_out = w_entry[EW-1 -: 7];
        end
        if (w_hold_data) begin
            d_out1 = w_entry[4*WIDTH-1 -: WIDTH];
            d_out2 = w_entry[3*WIDTH-1 -: WIDTH];
            d_out3 = w_entry[2*WIDTH-1 -: WIDTH];
            d_out4 = w_entry[WIDTH-1:0];
        end
    end

    // Program counter, timeout counter, error flags and captured results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_last        <= '0;
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
            r_err_seen    <= 1'b0;
            r_last_result <= '0;
            r_last_zero   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_pc          <= '0;
                r_last        <= last_idx;
                r_timeout_err <= 1'b0;
                r_err_seen    <= 1'b0;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (is_wait_state(r_state)) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (r_state == CAPTURE) begin
                r_last_result <= res_in;
                r_last_zero   <= zero_in;
                r_err_seen    <= r_err_seen | error_in;
                if (r_pc != r_last) begin
                    r_pc <= r_pc + AW'(1);
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign timeout_err = r_timeout_err;
    assign err_seen    = r_err_seen;
    assign last_result = r_last_result;
    assign last_zero   = r_last_zero;

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Directed testbench for cpu_cmd_sequencer with a small behavioural CPU model.
// CPU model: on seeing a command, drops cpu_rdy one cycle later, holds it low
// for 3 cycles, then returns res = d1*d2, zero = (res==0), error = d3[0].
module tb_cpu_cmd_sequencer;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int AW      = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [AW-1:0]       last_idx = '0;
    logic                prog_we = 1'b0;
    logic [AW-1:0]       prog_addr = '0;
    logic [7+4*WIDTH-1:0] prog_wdata = '0;
    logic [6:0]          cmd_out;
    logic [WIDTH-1:0]    d_out1, d_out2, d_out3, d_out4;
    logic                cpu_rdy;
    logic [2*WIDTH-1:0]  res_in;
    logic                zero_in;
    logic                error_in;
    logic                busy, done, timeout_err, err_seen, last_zero;
    logic [2*WIDTH-1:0]  last_result;
`ifdef CPU_SEQ_RESULT_LOG_EN
    logic [AW-1:0]       res_addr = '0;
    logic [2*WIDTH+1:0]  res_data;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [6:0] cmd_log[$];
    int done_cnt = 0;
    bit cpu_stuck = 1'b0;

    always #5 clk = ~clk;

    cpu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .last_idx(last_idx),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .cmd_out(cmd_out), .d_out1(d_out1), .d_out2(d_out2), .d_out3(d_out3), .d_out4(d_out4),
        .cpu_rdy(cpu_rdy), .res_in(res_in), .zero_in(zero_in), .error_in(error_in),
        .busy(busy), .done(done), .timeout_err(timeout_err), .err_seen(err_seen),
        .last_result(last_result), .last_zero(last_zero)
`ifdef CPU_SEQ_RESULT_LOG_EN
        , .res_addr(res_addr), .res_data(res_data)
`endif
    );

    // Monitors: every non-NOP command cycle and every done cycle.
    always @(negedge clk) if (cmd_out !== 7'h00) cmd_log.push_back(cmd_out);
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Behavioural CPU.
    initial begin
        logic [WIDTH-1:0] l1, l2, l3;
        cpu_rdy = 1'b1; res_in = '0; zero_in = 1'b0; error_in = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_stuck) begin
                cpu_rdy = 1'b0;
            end else if (cmd_out !== 7'h00) begin
                l1 = d_out1; l2 = d_out2; l3 = d_out3;
                @(negedge clk);
                cpu_rdy = 1'b0;
                repeat (3) @(negedge clk);
                res_in   = 16'(l1) * 16'(l2);
                zero_in  = (l1 == 0) || (l2 == 0);
                error_in = l3[0];
                cpu_rdy  = 1'b1;
            end else begin
                cpu_rdy = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic load(input logic [AW-1:0] a, input logic [6:0] c,
                        input logic [7:0] a1, input logic [7:0] a2,
                        input logic [7:0] a3, input logic [7:0] a4);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = {c, a1, a2, a3, a4};
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Start pulse; returns at the negedge after the sampling edge.
    task automatic kick(input logic [AW-1:0] li);
        @(negedge clk);
        last_idx = li; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 200) begin
            if (done === 1'b1) seen = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (cmd_out !== 7'h00) begin n_bad++; $display("FAIL reset_cmd: got %h want 00", cmd_out); end
        n_vec++; if ((d_out1 | d_out2 | d_out3 | d_out4) !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h %h %h %h want 0", d_out1, d_out2, d_out3, d_out4); end
        n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
        n_vec++; if (err_seen !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_seen); end
        n_vec++; if (last_result !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h want 0000", last_result); end
        n_vec++; if (last_zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero: got %b want 0", last_zero); end
`ifdef CPU_SEQ_RESULT_LOG_EN
        res_addr = 2'd3; #1;
        n_vec++; if (res_data !== 18'h0) begin n_bad++; $display("FAIL reset_log: got %h want 0", res_data); end
`endif
    endtask

    task automatic test_single();
        int base, dbase, cyc; bit seen;
        load(2'd0, 7'h05, 8'h03, 8'h04, 8'h00, 8'h00);
        base = cmd_log.size(); dbase = done_cnt;
        kick(2'd0);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: got %b want 1", busy); end
        n_vec++; if (cmd_out !== 7'h00) begin n_bad++; $display("FAIL single_cmd_early: got %h want 00", cmd_out); end
        @(negedge clk);
        n_vec++; if (cmd_out !== 7'h05) begin n_bad++; $display("FAIL single_cmd_issue: got %h want 05", cmd_out); end
        n_vec++; if ({d_out1, d_out2} !== 16'h0304) begin n_bad++; $display("FAIL single_data_issue: got %h%h want 0304", d_out1, d_out2); end
        @(negedge clk);
        n_vec++; if (cmd_out !== 7'h00) begin n_bad++; $display("FAIL single_cmd_nop: got %h want 00", cmd_out); end
        n_vec++; if (d_out1 !== 8'h03) begin n_bad++; $display("FAIL single_data_hold: got %h want 03", d_out1); end
        wait_done(cyc, seen);
        n_vec++; if (!seen) begin n_bad++; $display("FAIL single_done_wait: got no done want done"); end
        n_vec++; if (last_result !== 16'h000C) begin n_bad++; $display("FAIL single_result: got %h want 000c", last_result); end
        n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL single_tmo: got %b want 0", timeout_err); end
        @(negedge clk);
        n_vec++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL single_end: got busy/done %b want 00", {busy, done}); end
        repeat (2) @(negedge clk);
        n_vec++; if (cmd_log.size() - base != 1) begin n_bad++; $display("FAIL single_cmd_count: got %0d want 1", cmd_log.size() - base); end
        n_vec++; if (done_cnt - dbase != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - dbase); end
    endtask

    task automatic test_four_entry();
        int base, dbase, cyc; bit seen;
        logic [6:0]  exp_cmd [4] = '{7'h05, 7'h06, 7'h07, 7'h08};
        logic [17:0] exp_log [4] = '{18'h00006, 18'h00014, 18'h00100, 18'h0FE01};
        logic [6:0]  got;
        load(2'd0, 7'h05, 8'h02, 8'h03, 8'h00, 8'h00);
        load(2'd1, 7'h06, 8'h04, 8'h05, 8'h00, 8'h00);
        load(2'd2, 7'h07, 8'h10, 8'h10, 8'h00, 8'h00);
        load(2'd3, 7'h08, 8'hFF, 8'hFF, 8'h00, 8'h00);
        base = cmd_log.size(); dbase = done_cnt;
        kick(2'd3);
        wait_done(cyc, seen);
        n_vec++; if (!seen) begin n_bad++; $display("FAIL four_done_wait: got no done want done"); end
        n_vec++; if (last_result !== 16'hFE01) begin n_bad++; $display("FAIL four_result: got %h want fe01", last_result); end
        n_vec++; if (last_zero !== 1'b0) begin n_bad++; $display("FAIL four_zero: got %b want 0", last_zero); end
        repeat (3) @(negedge clk);
        n_vec++; if (cmd_log.size() - base != 4) begin n_bad++; $display("FAIL four_cmd_count: got %0d want 4", cmd_log.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < cmd_log.size()) ? cmd_log[base + i] : 7'h7F;
            n_vec++; if (got !== exp_cmd[i]) begin n_bad++; $display("FAIL four_cmd_seq[%0d]: got %h want %h", i, got, exp_cmd[i]); end
        end
        n_vec++; if (done_cnt - dbase != 1) begin n_bad++; $display("FAIL four_done_count: got %0d want 1", done_cnt - dbase); end
`ifdef CPU_SEQ_RESULT_LOG_EN
        for (int i = 0; i < 4; i++) begin
            res_addr = AW'(i); #1;
            n_vec++; if (res_data !== exp_log[i]) begin n_bad++; $display("FAIL four_log[%0d]: got %h want %h", i, res_data, exp_log[i]); end
        end
`else
        n_vec++; if (exp_log[3][15:0] !== last_result) begin n_bad++; $display("FAIL four_final: got %h want %h", last_result, exp_log[3][15:0]); end
`endif
    endtask

    task automatic test_timeout();
        int base, cyc; bit seen;
        cpu_stuck = 1'b1;
        repeat (2) @(negedge clk);
        base = cmd_log.size();
        kick(2'd3);
        wait_done(cyc, seen);
        n_vec++; if (!seen) begin n_bad++; $display("FAIL tmo_done_wait: got no done want done"); end
        n_vec++; if (cyc != 8) begin n_bad++; $display("FAIL tmo_latency: got %0d want 8", cyc); end
        n_vec++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy_end: got %b want 0", busy); end
        n_vec++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
        n_vec++; if (cmd_log.size() - base != 0) begin n_bad++; $display("FAIL tmo_no_cmd: got %0d want 0", cmd_log.size() - base); end
        n_vec++; if (last_result !== 16'hFE01) begin n_bad++; $display("FAIL tmo_result_kept: got %h want fe01", last_result); end
        cpu_stuck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_error_flag();
        int cyc; bit seen;
        load(2'd0, 7'h09, 8'h01, 8'h01, 8'h00, 8'h00);
        load(2'd1, 7'h0A, 8'h00, 8'h07, 8'h01, 8'h00);
        load(2'd2, 7'h0B, 8'h02, 8'h02, 8'h00, 8'h00);
        kick(2'd2);
        n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL err_tmo_cleared: got %b want 0", timeout_err); end
        wait_done(cyc, seen);
        n_vec++; if (!seen) begin n_bad++; $display("FAIL err_done_wait: got no done want done"); end
        n_vec++; if (err_seen !== 1'b1) begin n_bad++; $display("FAIL err_seen_set: got %b want 1", err_seen); end
        n_vec++; if (last_zero !== 1'b0) begin n_bad++; $display("FAIL err_last_zero: got %b want 0", last_zero); end
        n_vec++; if (last_result !== 16'h0004) begin n_bad++; $display("FAIL err_result: got %h want 0004", last_result); end
        n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL err_no_tmo: got %b want 0", timeout_err); end
`ifdef CPU_SEQ_RESULT_LOG_EN
        res_addr = 2'd1; #1;
        n_vec++; if (res_data !== 18'h30000) begin n_bad++; $display("FAIL err_log1: got %h want 30000", res_data); end
        res_addr = 2'd3; #1;
        n_vec++; if (res_data !== 18'h0FE01) begin n_bad++; $display("FAIL err_log3_kept: got %h want 0fe01", res_data); end
`endif
        @(negedge clk);
        kick(2'd0);
        n_vec++; if (err_seen !== 1'b0) begin n_bad++; $display("FAIL err_seen_clear: got %b want 0", err_seen); end
        wait_done(cyc, seen);
        n_vec++; if (!seen) begin n_bad++; $display("FAIL err_rerun_wait: got no done want done"); end
        n_vec++; if ({err_seen, last_result} !== 17'h00001) begin n_bad++; $display("FAIL err_rerun: got %b/%h want 0/0001", err_seen, last_result); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int base, dbase, cyc; bit seen;
        logic [6:0] got;
        load(2'd0, 7'h11, 8'h03, 8'h03, 8'h00, 8'h00);
        load(2'd1, 7'h12, 8'h05, 8'h05, 8'h00, 8'h00);
        base = cmd_log.size(); dbase = done_cnt;
        kick(2'd1);
        start = 1'b1; last_idx = 2'd0;
        prog_we = 1'b1; prog_addr = 2'd1; prog_wdata = {7'h7F, 8'hFF, 8'hFF, 8'h00, 8'h00};
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_done(cyc, seen);
        n_vec++; if (!seen) begin n_bad++; $display("FAIL ign_done_wait: got no done want done"); end
        n_vec++; if (last_result !== 16'h0019) begin n_bad++; $display("FAIL ign_result: got %h want 0019", last_result); end
        repeat (10) @(negedge clk);
        n_vec++; if (cmd_log.size() - base != 2) begin n_bad++; $display("FAIL ign_cmd_count: got %0d want 2", cmd_log.size() - base); end
        got = (base + 1 < cmd_log.size()) ? cmd_log[base + 1] : 7'h7F;
        n_vec++; if (got !== 7'h12) begin n_bad++; $display("FAIL ign_second_cmd: got %h want 12", got); end
        n_vec++; if (done_cnt - dbase != 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - dbase); end
        kick(2'd1);
        wait_done(cyc, seen);
        n_vec++; if (last_result !== 16'h0019) begin n_bad++; $display("FAIL ign_prog_kept: got %h want 0019", last_result); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int base; bit found;
        load(2'd0, 7'h05, 8'h02, 8'h03, 8'h00, 8'h00);
        load(2'd1, 7'h06, 8'h04, 8'h05, 8'h00, 8'h00);
        load(2'd2, 7'h07, 8'h10, 8'h10, 8'h00, 8'h00);
        base = cmd_log.size();
        kick(2'd3);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            if (cmd_log.size() - base >= 3) found = 1'b1;
        end
        n_vec++; if (!found) begin n_bad++; $display("FAIL mid_third_issue: got none want cmd 07"); end
        repeat (2) @(negedge clk);
        n_vec++; if ({busy, cmd_out, d_out1} !== {1'b1, 7'h00, 8'h10}) begin n_bad++; $display("FAIL mid_in_wait_done: got %b/%h/%h want 1/00/10", busy, cmd_out, d_out1); end
        n_vec++; if (last_result !== 16'h0014) begin n_bad++; $display("FAIL mid_prior_result: got %h want 0014", last_result); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_vec++; if (cmd_out !== 7'h00) begin n_bad++; $display("FAIL mid_cmd: got %h want 00", cmd_out); end
        n_vec++; if (last_result !== 16'h0000) begin n_bad++; $display("FAIL mid_result: got %h want 0000", last_result); end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++; if (cmd_log.size() - base != 3) begin n_bad++; $display("FAIL mid_no_more_cmds: got %0d want 3", cmd_log.size() - base); end
`ifdef CPU_SEQ_RESULT_LOG_EN
        res_addr = 2'd0; #1;
        n_vec++; if (res_data !== 18'h0) begin n_bad++; $display("FAIL mid_log_cleared: got %h want 0", res_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_entry();
        test_timeout();
        test_error_flag();
        test_ignore_busy();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
